// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, error bit positions and timeout sizing for
// the UART frame parser.
package uart_pkg;

  // Parser states; DRAIN is the only state that drives the output stream.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHK     = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  // Bit positions inside err_o.
  localparam int ERR_W   = 4;
  localparam int ERR_LEN = 0;
  localparam int ERR_CHK = 1;
  localparam int ERR_TMO = 2;
  localparam int ERR_OVR = 3;

  // Inter-byte timeout in clock cycles: chars * 10 bit times, one bit time
  // being the integer number of clocks per baud period.
  function automatic int timeout_cycles(input int clkfreq, input int baudrate,
                                        input int chars);
    return chars * 10 * (clkfreq / baudrate);
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: payload store for one frame. Synchronous write, combinational
// read so the parser can present the next byte in the same cycle it advances.
module uart_frame_buf
  import uart_pkg::*;
#(
  parameter int p_depth = 16,
  parameter int p_aw    = 4
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [p_aw-1:0] waddr_i,
  input  logic [7:0]      wdata_i,
  input  logic [p_aw-1:0] raddr_i,
  output logic [7:0]      rdata_o
);

  // Contents are not reset: every byte read in a drain was written by the
  // same frame beforehand.
  logic [7:0] mem_q [p_depth];

  // Store one payload byte per write strobe.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_frame_parser.sv
// uart_rx_frame_parser: delimits SOF/LEN/payload/XOR-checksum frames from the
// uart_rx byte stream, buffers the payload and releases it on a valid/ready
// stream only after the checksum matches. Errors are single-cycle pulses.
module uart_rx_frame_parser
  import uart_pkg::*;
#(
  parameter int         p_clkfreq       = 100_000_000,
  parameter int         p_baudrate      = 115_200,
  parameter logic [7:0] p_sof           = 8'hA5,
  parameter int         p_max_len       = 16,
  parameter int         p_timeout_chars = 4
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic [7:0]       din_i,
  input  logic             din_tick_i,
  output logic [7:0]       m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic             m_last_o,
  output logic             frame_ok_o,
  output logic [ERR_W-1:0] err_o,
  output logic             busy_o
);

  // Pointer/length width holds 0..p_max_len; buffer address only 0..p_max_len-1.
  localparam int PW = $clog2(p_max_len + 1);
  localparam int AW = (p_max_len > 1) ? $clog2(p_max_len) : 1;

  localparam int TMO_T = timeout_cycles(p_clkfreq, p_baudrate, p_timeout_chars);
  localparam int TW    = $clog2(TMO_T + 1);

  localparam logic [TW-1:0] TMO_LIM  = TW'(TMO_T);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [7:0]    MAX_LEN8 = 8'(p_max_len);

  state_e           state_q;
  logic [PW-1:0]    len_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [7:0]       chk_q;
  logic [TW-1:0]    tmo_q;
  logic [7:0]       m_data_q;
  logic             m_valid_q;
  logic             m_last_q;
  logic             frame_ok_q;
  logic [ERR_W-1:0] err_q;
  logic             busy_q;

  logic [PW-1:0]    wr_ptr_nxt;
  logic [PW-1:0]    rd_ptr_nxt;
  logic [PW-1:0]    len_last;
  logic [TW-1:0]    tmo_nxt;
  logic             tmo_hit;
  logic             len_bad;
  logic             wr_en;
  logic [AW-1:0]    rd_addr_d;
  logic [7:0]       rd_data;

  assign wr_ptr_nxt = wr_ptr_q + PTR_ONE;
  assign rd_ptr_nxt = rd_ptr_q + PTR_ONE;
  assign len_last   = len_q - PTR_ONE;
  assign tmo_nxt    = tmo_q + TMO_ONE;
  assign tmo_hit    = (tmo_nxt == TMO_LIM);
  assign len_bad    = (din_i == 8'd0) || (din_i > MAX_LEN8);
  assign wr_en      = (state_q == PAYLOAD) && din_tick_i;

  // Read address is the pointer value that will be current after this edge,
  // so the registered m_data_o always shows buf[rd_ptr].
  always_comb begin
    rd_addr_d = rd_ptr_q[AW-1:0];
    if (state_q == CHK) begin
      rd_addr_d = '0;
    end else if ((state_q == DRAIN) && m_ready_i) begin
      rd_addr_d = rd_ptr_nxt[AW-1:0];
    end
  end

  uart_frame_buf #(
    .p_depth (p_max_len),
    .p_aw    (AW)
  ) u_buf (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (din_i),
    .raddr_i (rd_addr_d),
    .rdata_o (rd_data)
  );

  // Frame FSM with checksum, pointers, inter-byte timeout and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      len_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      chk_q      <= '0;
      tmo_q      <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      frame_ok_q <= 1'b0;
      err_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      // Status outputs are pulses unless re-asserted below.
      frame_ok_q <= 1'b0;
      err_q      <= '0;

      unique case (state_q)
        IDLE: begin
          // Hunt for SOF; anything else is dropped without complaint.
          if (din_tick_i && (din_i == p_sof)) begin
            state_q <= LEN;
            busy_q  <= 1'b1;
            tmo_q   <= '0;
          end
        end

        LEN, PAYLOAD, CHK: begin
          if (!din_tick_i) begin
            // Silence on the line: abandon the frame once the gap hits the limit.
            if (tmo_hit) begin
              err_q[ERR_TMO] <= 1'b1;
              state_q        <= IDLE;
              busy_q         <= 1'b0;
              tmo_q          <= '0;
            end else begin
              tmo_q <= tmo_nxt;
            end
          end else begin
            // A byte arriving on the limit cycle still counts as in time.
            tmo_q <= '0;
            if (state_q == LEN) begin
              if (len_bad) begin
                err_q[ERR_LEN] <= 1'b1;
                state_q        <= IDLE;
                busy_q         <= 1'b0;
              end else begin
                len_q    <= din_i[PW-1:0];
                chk_q    <= din_i;
                wr_ptr_q <= '0;
                state_q  <= PAYLOAD;
              end
            end else if (state_q == PAYLOAD) begin
              chk_q    <= chk_q ^ din_i;
              wr_ptr_q <= wr_ptr_nxt;
              if (wr_ptr_nxt == len_q) begin
                state_q <= CHK;
              end
            end else begin
              if (din_i == chk_q) begin
                // First byte goes out together with the frame_ok pulse.
                state_q    <= DRAIN;
                rd_ptr_q   <= '0;
                frame_ok_q <= 1'b1;
                m_valid_q  <= 1'b1;
                m_data_q   <= rd_data;
                m_last_q   <= (len_q == PTR_ONE);
              end else begin
                err_q[ERR_CHK] <= 1'b1;
                state_q        <= IDLE;
                busy_q         <= 1'b0;
              end
            end
          end
        end

        DRAIN: begin
          // Bytes arriving while draining are lost; the drain itself carries on.
          if (din_tick_i) begin
            err_q[ERR_OVR] <= 1'b1;
          end
          if (m_ready_i) begin
            if (m_last_q) begin
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
              state_q   <= IDLE;
              busy_q    <= 1'b0;
            end else begin
              rd_ptr_q <= rd_ptr_nxt;
              m_data_q <= rd_data;
              m_last_q <= (rd_ptr_nxt == len_last);
            end
          end
        end

        default: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          m_valid_q <= 1'b0;
          m_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign m_data_o   = m_data_q;
  assign m_valid_o  = m_valid_q;
  assign m_last_o   = m_last_q;
  assign frame_ok_o = frame_ok_q;
  assign err_o      = err_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// tb_uart_rx_frame_parser: table-driven frames, directed corner sequences and a
// randomized byte stream checked against a queue-based frame model.
module tb_uart_rx_frame_parser;

  localparam int         TMO  = 34720;
  localparam int         MAXL = 16;
  localparam logic [7:0] SOF  = 8'hA5;

  logic       clk        = 1'b0;
  logic       rst_n_i    = 1'b0;
  logic [7:0] din_i      = 8'h00;
  logic       din_tick_i = 1'b0;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_ready_i;
  logic       m_last_o;
  logic       frame_ok_o;
  logic [3:0] err_o;
  logic       busy_o;

  logic rdy_force = 1'b1;
  logic rnd_mode  = 1'b0;
  logic hold      = 1'b0;
  logic rnd_bit   = 1'b0;

  assign m_ready_i = rnd_mode ? (rnd_bit & ~hold) : rdy_force;

  uart_rx_frame_parser dut (
    .clk        (clk),
    .rst_n_i    (rst_n_i),
    .din_i      (din_i),
    .din_tick_i (din_tick_i),
    .m_data_o   (m_data_o),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .m_last_o   (m_last_o),
    .frame_ok_o (frame_ok_o),
    .err_o      (err_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: counts pulses, records transfers, flags protocol violations.
  int         n_ok   = 0;
  int         n_err[4] = '{0, 0, 0, 0};
  int         viol   = 0;
  logic [8:0] xq[$];
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  always @(negedge clk) begin
    if (!rst_n_i) begin
      prev_hold = 1'b0;
    end else begin
      if (frame_ok_o) n_ok++;
      for (int b = 0; b < 4; b++) if (err_o[b]) n_err[b]++;
      if ($countones(err_o) > 1 || (frame_ok_o && err_o != 4'h0)) viol++;
      if (prev_hold && (!m_valid_o || m_data_o != prev_data || m_last_o != prev_last)) viol++;
      if (m_valid_o && m_ready_i) xq.push_back({m_last_o, m_data_o});
      prev_hold = m_valid_o && !m_ready_i;
      prev_data = m_data_o;
      prev_last = m_last_o;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Byte is sampled at the next rising edge; din_i is parked at SOF while no
  // tick is present to show it is ignored.
  task automatic send_byte(input logic [7:0] b);
    din_i      = b;
    din_tick_i = 1'b1;
    @(posedge clk);
    #1;
    din_tick_i = 1'b0;
    din_i      = SOF;
  endtask

  typedef struct {
    int           n;
    logic [159:0] raw;
    int           exp_ok;
    logic [3:0]   exp_err;
    int           nout;
    int           off;
  } vec_t;

  vec_t vt[8];

  function automatic logic [7:0] vbyte(input vec_t v, input int i);
    return v.raw[8*(v.n-1-i) +: 8];
  endfunction

  // Reference model: frames recognised from the byte list by length/xor rules.
  logic [7:0] pend[$];
  logic [8:0] mq[$];
  int         m_ok = 0;
  int         m_err[4] = '{0, 0, 0, 0};

  task automatic model_byte(input logic [7:0] b, output bit got_ok);
    logic [7:0] x;
    int         sz;
    got_ok = 1'b0;
    if (pend.size() == 0) begin
      if (b == SOF) pend.push_back(b);
    end else begin
      pend.push_back(b);
      sz = pend.size();
      if (sz == 2 && (pend[1] == 8'd0 || int'(pend[1]) > MAXL)) begin
        m_err[0]++;
        pend.delete();
      end else if (sz > 2 && sz == int'(pend[1]) + 3) begin
        x = 8'h00;
        for (int k = 1; k < sz - 1; k++) x ^= pend[k];
        if (x == pend[sz-1]) begin
          m_ok++;
          for (int k = 2; k < sz - 1; k++) mq.push_back({k == sz - 2, pend[k]});
          got_ok = 1'b1;
        end else begin
          m_err[1]++;
        end
        pend.delete();
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         ok0, q0, q0r, ok0r, w, L, kind;
    int         e0[4];
    int         e0r[4];
    bit         got;
    logic [7:0] frm[$];
    logic [7:0] x, p, ob;

    vt[0] = '{6,  160'hA5_03_52_B5_55_B1, 1, 4'b0000, 3, 2};
    vt[1] = '{6,  160'hA5_03_52_B5_55_B0, 0, 4'b0010, 0, 0};
    vt[2] = '{6,  160'hA5_03_52_B5_55_B1, 1, 4'b0000, 3, 2};
    vt[3] = '{6,  160'hA5_00_A5_01_7E_7F, 1, 4'b0001, 1, 4};
    vt[4] = '{6,  160'hA5_11_A5_01_7E_7F, 1, 4'b0001, 1, 4};
    vt[5] = '{8,  160'h52_B5_A5_03_52_B5_55_B1, 1, 4'b0000, 3, 4};
    vt[6] = '{19, 160'hA5_10_00_01_02_03_04_05_06_07_08_09_0A_0B_0C_0D_0E_0F_10, 1, 4'b0000, 16, 2};
    vt[7] = '{9,  160'hA5_A5_01_7E_7F_A5_01_7E_7F, 1, 4'b0001, 1, 7};

    // Reset state
    idle(3);
    check("rst_valid", 32'(m_valid_o), 32'h0);
    check("rst_last", 32'(m_last_o), 32'h0);
    check("rst_ok", 32'(frame_ok_o), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_data", 32'(m_data_o), 32'h0);
    rst_n_i = 1'b1;
    idle(2);

    // Good frame at line rate: latency and back-to-back drain
    ok0 = n_ok;
    send_byte(8'hA5); idle(867);
    send_byte(8'h03); idle(867);
    send_byte(8'h52); idle(867);
    send_byte(8'hB5); idle(867);
    send_byte(8'h55); idle(867);
    send_byte(8'hB1);
    check("lat_ok", 32'(frame_ok_o), 32'h1);
    check("lat_valid", 32'(m_valid_o), 32'h1);
    check("lat_d0", 32'(m_data_o), 32'h52);
    check("lat_l0", 32'(m_last_o), 32'h0);
    idle(1);
    check("lat_d1", 32'(m_data_o), 32'hB5);
    check("lat_l1", 32'(m_last_o), 32'h0);
    check("lat_ok_pulse", 32'(frame_ok_o), 32'h0);
    idle(1);
    check("lat_d2", 32'(m_data_o), 32'h55);
    check("lat_l2", 32'(m_last_o), 32'h1);
    idle(1);
    check("lat_valid_end", 32'(m_valid_o), 32'h0);
    check("lat_busy_end", 32'(busy_o), 32'h0);
    idle(1);
    check("lat_okcnt", n_ok - ok0, 1);

    // Table-driven frames
    for (int v = 0; v < 8; v++) begin
      ok0 = n_ok;
      q0  = xq.size();
      for (int b = 0; b < 4; b++) e0[b] = n_err[b];
      for (int i = 0; i < vt[v].n; i++) begin
        send_byte(vbyte(vt[v], i));
        idle(2);
      end
      idle(30);
      check($sformatf("vec%0d_ok", v), n_ok - ok0, vt[v].exp_ok);
      for (int b = 0; b < 4; b++)
        check($sformatf("vec%0d_err%0d", v, b), n_err[b] - e0[b], 32'(vt[v].exp_err[b]));
      check($sformatf("vec%0d_nout", v), xq.size() - q0, vt[v].nout);
      for (int i = 0; i < vt[v].nout; i++)
        if (q0 + i < xq.size())
          check($sformatf("vec%0d_out%0d", v, i), 32'(xq[q0+i]),
                32'({i == vt[v].nout - 1, vbyte(vt[v], vt[v].off + i)}));
      check($sformatf("vec%0d_busy", v), 32'(busy_o), 32'h0);
    end
    check("table_viol", viol, 0);

    // Backpressure with an overrun byte during the drain
    rdy_force = 1'b0;
    ok0 = n_ok;
    q0  = xq.size();
    for (int b = 0; b < 4; b++) e0[b] = n_err[b];
    send_byte(8'hA5); idle(2);
    send_byte(8'h03); idle(2);
    send_byte(8'h52); idle(2);
    send_byte(8'hB5); idle(2);
    send_byte(8'h55); idle(2);
    send_byte(8'hB1);
    check("bp_valid", 32'(m_valid_o), 32'h1);
    check("bp_d0", 32'(m_data_o), 32'h52);
    idle(3);
    check("bp_hold_valid", 32'(m_valid_o), 32'h1);
    check("bp_hold_data", 32'(m_data_o), 32'h52);
    send_byte(8'hA5);
    check("ovr_err", 32'(err_o), 32'h8);
    check("ovr_data", 32'(m_data_o), 32'h52);
    check("ovr_valid", 32'(m_valid_o), 32'h1);
    idle(2);
    check("ovr_err_pulse", 32'(err_o), 32'h0);
    check("ovr_busy", 32'(busy_o), 32'h1);
    rdy_force = 1'b1;
    idle(6);
    check("bp_nout", xq.size() - q0, 3);
    if (xq.size() - q0 == 3) begin
      check("bp_o0", 32'(xq[q0]), 32'h052);
      check("bp_o1", 32'(xq[q0+1]), 32'h0B5);
      check("bp_o2", 32'(xq[q0+2]), 32'h155);
    end
    check("bp_okcnt", n_ok - ok0, 1);
    check("bp_ovrcnt", n_err[3] - e0[3], 1);
    check("bp_othererr", (n_err[0] - e0[0]) + (n_err[1] - e0[1]) + (n_err[2] - e0[2]), 0);
    check("bp_busy_end", 32'(busy_o), 32'h0);

    // Reset in the middle of the payload
    send_byte(8'hA5); idle(2);
    send_byte(8'h03); idle(2);
    send_byte(8'h52); idle(2);
    rst_n_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n_i = 1'b1;
    check("mrst_valid", 32'(m_valid_o), 32'h0);
    check("mrst_last", 32'(m_last_o), 32'h0);
    check("mrst_ok", 32'(frame_ok_o), 32'h0);
    check("mrst_err", 32'(err_o), 32'h0);
    check("mrst_busy", 32'(busy_o), 32'h0);
    check("mrst_data", 32'(m_data_o), 32'h0);
    ok0 = n_ok;
    q0  = xq.size();
    for (int b = 0; b < 4; b++) e0[b] = n_err[b];
    send_byte(8'hB5); idle(2);
    send_byte(8'h55); idle(2);
    send_byte(8'hB1); idle(5);
    check("mrst_tail_ok", n_ok - ok0, 0);
    check("mrst_tail_err", (n_err[0] - e0[0]) + (n_err[1] - e0[1]) + (n_err[2] - e0[2]) + (n_err[3] - e0[3]), 0);
    check("mrst_tail_out", xq.size() - q0, 0);
    check("mrst_tail_busy", 32'(busy_o), 32'h0);

    // Junk then timeout after the first payload byte
    for (int b = 0; b < 4; b++) e0[b] = n_err[b];
    send_byte(8'h52); idle(2);
    send_byte(8'hB5); idle(2);
    check("junk_busy", 32'(busy_o), 32'h0);
    send_byte(8'hA5); idle(2);
    send_byte(8'h03); idle(2);
    send_byte(8'h52);
    idle(TMO - 1);
    check("tmo_early", 32'(err_o), 32'h0);
    check("tmo_busy_before", 32'(busy_o), 32'h1);
    idle(1);
    check("tmo_err", 32'(err_o), 32'h4);
    check("tmo_busy_after", 32'(busy_o), 32'h0);
    idle(2);
    check("tmo_cnt", n_err[2] - e0[2], 1);
    check("tmo_other", (n_err[0] - e0[0]) + (n_err[1] - e0[1]) + (n_err[3] - e0[3]), 0);

    // Byte arriving on the limit cycle is accepted
    ok0 = n_ok;
    q0  = xq.size();
    send_byte(8'hA5); idle(2);
    send_byte(8'h03); idle(2);
    send_byte(8'h52);
    idle(TMO - 1);
    send_byte(8'hB5);
    check("edge_err", 32'(err_o), 32'h0);
    check("edge_busy", 32'(busy_o), 32'h1);
    idle(2);
    send_byte(8'h55); idle(2);
    send_byte(8'hB1);
    check("edge_ok", 32'(frame_ok_o), 32'h1);
    idle(6);
    check("edge_tmo_cnt", n_err[2] - e0[2], 1);
    check("edge_nout", xq.size() - q0, 3);
    check("edge_okcnt", n_ok - ok0, 1);

    // Randomized stream against the reference model
    ok0r = n_ok;
    q0r  = xq.size();
    for (int b = 0; b < 4; b++) e0r[b] = n_err[b];
    rnd_mode = 1'b1;
    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 5);
      frm.delete();
      if (kind <= 3) begin
        L = $urandom_range(1, MAXL);
        x = 8'(L);
        frm.push_back(SOF);
        frm.push_back(8'(L));
        for (int i = 0; i < L; i++) begin
          p = 8'($urandom);
          x ^= p;
          frm.push_back(p);
        end
        if (kind == 3) x ^= 8'($urandom_range(1, 255));
        frm.push_back(x);
      end else if (kind == 4) begin
        frm.push_back(SOF);
        frm.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255)));
      end else begin
        p = 8'($urandom);
        if (p == SOF) p = 8'h00;
        frm.push_back(p);
      end
      for (int i = 0; i < frm.size(); i++) begin
        model_byte(frm[i], got);
        send_byte(frm[i]);
        if (got) begin
          if ($urandom_range(0, 2) == 0) begin
            hold = 1'b1;
            idle(1);
            ob = ($urandom_range(0, 1) == 0) ? SOF : 8'($urandom);
            send_byte(ob);
            m_err[3]++;
            hold = 1'b0;
          end
          w = 0;
          while ((xq.size() - q0r) != mq.size() && w < 400) begin
            idle(1);
            w++;
          end
          check("rnd_drain_done", xq.size() - q0r, mq.size());
        end else begin
          idle($urandom_range(0, 3));
        end
      end
    end
    rnd_mode = 1'b0;
    idle(5);
    check("rnd_ok", n_ok - ok0r, m_ok);
    for (int b = 0; b < 4; b++)
      check($sformatf("rnd_err%0d", b), n_err[b] - e0r[b], m_err[b]);
    check("rnd_nout", xq.size() - q0r, mq.size());
    for (int i = 0; i < mq.size(); i++)
      if (q0r + i < xq.size())
        check($sformatf("rnd_out%0d", i), 32'(xq[q0r+i]), 32'(mq[i]));
    check("rnd_busy", 32'(busy_o), 32'h0);
    check("viol_total", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_parser.md
Name: uart_rx_frame_parser

Overview:
- Sits directly downstream of uart_rx and consumes its dout_o / rx_done_tick_o byte stream.
- Delimits frames of the form SOF, LEN, LEN payload bytes, XOR checksum.
- Buffers the payload and releases it on a valid/ready byte stream only when the checksum matches.
- Flags length, checksum, inter-byte timeout and overrun errors as single-cycle pulses.

Parameters:
- p_clkfreq, 100_000_000: clock frequency in Hz.
- p_baudrate, 115_200: line baud rate; used only for the timeout.
- p_sof, 8'hA5: start-of-frame byte.
- p_max_len, 16: maximum payload length and buffer depth in bytes.
- p_timeout_chars, 4: allowed inter-byte gap in character times (10 bit times each).

Ports:
- clk  input  1  system clock.
- rst_n_i  input  1  reset, synchronous, active-low.
- din_i  input  8  received byte; connects to uart_rx dout_o.
- din_tick_i  input  1  one-cycle byte-valid strobe; connects to uart_rx rx_done_tick_o.
- m_data_o  output  8  payload byte out.
- m_valid_o  output  1  m_data_o is valid.
- m_ready_i  input  1  downstream accepts the byte.
- m_last_o  output  1  the current m_data_o is the final payload byte.
- frame_ok_o  output  1  one-cycle pulse: a frame was accepted.
- err_o  output  4  one-cycle error pulses: [0] length, [1] checksum, [2] timeout, [3] overrun.
- busy_o  output  1  high whenever the state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low. While rst_n_i is low at a clk edge, the following all clear to 0: state (goes to IDLE), pointers, length register, checksum accumulator, timeout counter, m_valid_o, m_last_o, frame_ok_o, err_o, busy_o. m_data_o also resets to 0. Buffer contents are don't-care.
- Reset mid-frame or mid-drain: the frame is abandoned and nothing further is emitted.
- Input sampling: a byte is taken only when din_tick_i is high. din_i is ignored otherwise.
- States:
  - IDLE: a byte equal to p_sof goes to LEN. Any other byte is dropped silently, with no error.
  - LEN: the byte is the length L.
    - If L = 0 or L > p_max_len: pulse err_o[0] and return to IDLE.
    - Otherwise store L, set chk = L, set wr_ptr = 0, and go to PAYLOAD.
  - PAYLOAD: write buf[wr_ptr] = byte, chk ^= byte, wr_ptr++. After byte L is written, go to CHK.
  - CHK: compare the byte with chk.
    - Equal: go to DRAIN, set rd_ptr = 0, pulse frame_ok_o.
    - Not equal: pulse err_o[1], go to IDLE, and emit nothing.
  - DRAIN:
    - m_valid_o = 1, m_data_o = buf[rd_ptr], m_last_o = (rd_ptr == L-1).
    - A transfer occurs on m_valid_o & m_ready_i and advances rd_ptr.
    - The transfer with m_last_o high returns the state to IDLE. m_valid_o is low in the next cycle.
- Latency: checksum tick at edge N → frame_ok_o high and m_valid_o high in the cycle after N, with the first byte presented. With m_ready_i held high, L bytes take exactly L cycles.
- Handshake: m_data_o and m_last_o are held stable while m_valid_o is high and m_ready_i is low. m_valid_o never drops without a transfer, except on reset.
- Overrun: a din_tick_i in DRAIN drops the byte, including a p_sof byte, and pulses err_o[3]. The drain continues unaffected.
- Timeout:
  - Counter limit T = p_timeout_chars * 10 * (p_clkfreq / p_baudrate), with integer division. Default 4*10*868 = 34720 cycles.
  - Counting runs only in LEN, PAYLOAD and CHK. The counter clears on every accepted tick and on entry to those states.
  - Reaching T with no tick: pulse err_o[2] and go to IDLE.
  - A tick in the same cycle as the limit wins: the byte is processed and the counter clears.
  - Counter width is clog2(T+1).
- Error pulses: at most one err_o bit is set per cycle. frame_ok_o and err_o are never high in the same cycle.
- Widths: pointers and the length register are clog2(p_max_len+1) bits. L is compared at the full 8 bits.

Decomposition:
- Package uart_pkg holds:
  - state encodings: IDLE, LEN, PAYLOAD, CHK, DRAIN.
  - err_o bit indices: ERR_LEN = 0, ERR_CHK = 1, ERR_TMO = 2, ERR_OVR = 3.
  - a constant function computing the timeout count from p_clkfreq, p_baudrate and p_timeout_chars.
- One sub-module, uart_frame_buf: p_max_len x 8 register file with a synchronous write port and a combinational read port.
- The FSM, checksum, pointers and timeout live in the top module.

Test Plan:
- Good frame: bytes A5 03 52 B5 55 B1 at 8680 ns spacing, m_ready_i = 1 → m_data_o emits 52, B5, 55 on consecutive cycles. m_last_o is high only with 55. One frame_ok_o pulse, err_o = 0.
- Bad checksum: A5 03 52 B5 55 B0 → a single err_o[1] pulse, m_valid_o never high, state back in IDLE. A following good frame is then accepted.
- Length errors: A5 00 → err_o[0]. A5 11 (17) → err_o[0]. In both cases the next bytes are treated as IDLE hunting.
- Junk and timeout: leading 52 B5 before A5 are ignored. Then A5 03 52 followed by silence → err_o[2] exactly 34720 cycles after the 52 tick, busy_o low afterwards.
- Backpressure and overrun: good frame with m_ready_i = 0 → m_data_o is held at 52. A byte A5 injected during DRAIN → err_o[3] with no corruption. Releasing m_ready_i then yields 52, B5, 55.
- Reset mid-payload: rst_n_i low for 1 cycle after A5 03 52 → all outputs 0, busy_o = 0. The remaining B5 55 B1 produce no output and no error.
